// File: rtl/exception_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exc_pkg
//  Purpose  : Shared definitions for the exception sequencer: memory-address
//             mux select codes, exception cause codes, sequencer state
//             encoding, handler vector byte addresses and small helpers that
//             resolve simultaneous requests.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package exc_pkg;

    // Memory-address mux select codes
    localparam logic [2:0] SRC_PC     = 3'd0;
    localparam logic [2:0] SRC_ALUOUT = 3'd1;
    localparam logic [2:0] SRC_NOOP   = 3'd2;
    localparam logic [2:0] SRC_OVF    = 3'd3;
    localparam logic [2:0] SRC_DIV0   = 3'd4;
    localparam logic [2:0] SRC_ALURES = 3'd5;

    // Byte addresses of the handler vectors in memory
    localparam logic [7:0] VEC_NOOP = 8'd253;
    localparam logic [7:0] VEC_OVF  = 8'd254;
    localparam logic [7:0] VEC_DIV0 = 8'd255;

    // Latched exception cause
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_NOOP = 2'd1,
        CAUSE_OVF  = 2'd2,
        CAUSE_DIV0 = 2'd3
    } cause_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    // Resolve simultaneous requests: div0 beats overflow beats noop.
    // Losing requests are simply dropped.
    function automatic cause_t pick_cause(input logic div0,
                                          input logic ovf,
                                          input logic noop);
        cause_t c;
        c = CAUSE_NONE;
        if (div0)      c = CAUSE_DIV0;
        else if (ovf)  c = CAUSE_OVF;
        else if (noop) c = CAUSE_NOOP;
        return c;
    endfunction

    // Address-mux select that points memory at the vector for a cause
    function automatic logic [2:0] vector_select(input cause_t c);
        logic [2:0] sel;
        sel = SRC_PC;
        case (c)
            CAUSE_NOOP: sel = SRC_NOOP;
            CAUSE_OVF:  sel = SRC_OVF;
            CAUSE_DIV0: sel = SRC_DIV0;
            default:    sel = SRC_PC;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exception_sequencer_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : exc_wait_counter
//  Purpose  : Loadable 3-bit down-counter that times the memory read of the
//             handler vector. A load pulse arms it; while enabled it counts
//             down and 'expired' is high during the MEM_LAT-th enabled cycle.
//  Ports    : clk     - clock, rising edge
//             reset   - synchronous reset, active-low (clears the count)
//             load    - arm the counter for a fresh MEM_LAT-cycle wait
//             en      - count this cycle
//             expired - current cycle is the last cycle of the wait
//  Params   : MEM_LAT - memory read latency in cycles (1..7)
//  Revision : 1.0 - initial release
// ============================================================================
module exc_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    // Out-of-range latencies are clamped into what 3 bits can time.
    localparam int LAT_CLAMPED = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 7) ? 7 : MEM_LAT);

    // Loading LAT-1 makes the count reach zero on the LAT-th enabled cycle,
    // so 'expired' can be decoded directly from zero.
    localparam logic [2:0] LOAD_VALUE = 3'(LAT_CLAMPED - 1);

    logic [2:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 3'd0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (en && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign expired = (count == 3'd0);

endmodule
`default_nettype wire

// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exception_sequencer
//  Purpose  : Multicycle-CPU exception controller. On an invalid-opcode,
//             overflow or divide-by-zero request it takes over the
//             memory-address mux, saves EPC, points memory at the matching
//             vector byte, waits MEM_LAT cycles for the read, then loads PC
//             with the zero-extended handler byte. While idle the main
//             control unit's select passes straight through.
//  Ports    : clk          - clock, rising edge
//             reset        - synchronous reset, active-low
//             ctrl_src     - [2:0] mux select from the main control unit
//             exc_noop     - invalid-opcode request
//             exc_ovf      - overflow request
//             exc_div0     - divide-by-zero request
//             pc_in        - [31:0] current PC (already +4)
//             mem_data_in  - [31:0] memory read data, handler byte in [7:0]
//             src_add_mem  - [2:0] select driven to the address mux
//             busy         - sequencer owns the mux; main control stalls
//             epc_wr       - EPC write enable
//             epc_out      - [31:0] EPC write value (0 when not writing)
//             pc_wr        - PC write enable
//             pc_out       - [31:0] PC write value (0 when not writing)
//             exc_cause    - [1:0] latched cause: 0 none/1 noop/2 ovf/3 div0
//             done         - one-cycle pulse when the handler PC is loaded
//  Params   : MEM_LAT      - memory read latency in cycles (1..7)
//  Config   : EXC_EPC_EN   - when defined, the SAVE state writes EPC;
//                            otherwise epc_wr/epc_out are tied to 0 while
//                            the state sequence and timing stay the same.
//  Revision : 1.0 - initial release
// ============================================================================
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ctrl_src,
    input  logic        exc_noop,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  src_add_mem,
    output logic        busy,
    output logic        epc_wr,
    output logic [31:0] epc_out,
    output logic        pc_wr,
    output logic [31:0] pc_out,
    output logic [1:0]  exc_cause,
    output logic        done
);

    state_t     state;
    logic [2:0] vec_sel;       // vector select held for the whole sequence
    logic       any_exc;
    cause_t     new_cause;
    logic       wait_expired;

    // Only the handler byte of the read data is ever used.
    logic       unused_mem_hi;
    assign unused_mem_hi = ^mem_data_in[31:8];

    assign any_exc   = exc_noop | exc_ovf | exc_div0;
    assign new_cause = pick_cause(exc_div0, exc_ovf, exc_noop);

    // ------------------------------------------------------------------
    // Read-latency timer: armed during SAVE, counts through WAIT.
    // ------------------------------------------------------------------
    exc_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (state == ST_SAVE),
        .en      (state == ST_WAIT),
        .expired (wait_expired)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs. Write enables and their data
    // default to zero every cycle so the data buses read 0 whenever the
    // matching enable is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            vec_sel   <= SRC_PC;
            busy      <= 1'b0;
            pc_wr     <= 1'b0;
            pc_out    <= 32'd0;
            exc_cause <= CAUSE_NONE;
            done      <= 1'b0;
`ifdef EXC_EPC_EN
            epc_wr    <= 1'b0;
            epc_out   <= 32'd0;
`endif
        end else begin
            pc_wr   <= 1'b0;
            pc_out  <= 32'd0;
            done    <= 1'b0;
`ifdef EXC_EPC_EN
            epc_wr  <= 1'b0;
            epc_out <= 32'd0;
`endif
            case (state)
                ST_IDLE: begin
                    if (any_exc) begin
                        state     <= ST_SAVE;
                        busy      <= 1'b1;
                        vec_sel   <= vector_select(new_cause);
                        exc_cause <= new_cause;
`ifdef EXC_EPC_EN
                        // pc_in already points past the faulting
                        // instruction; step back one word (wraps at 0).
                        epc_wr    <= 1'b1;
                        epc_out   <= pc_in - 32'd4;
`endif
                    end
                end
                ST_SAVE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_expired) begin
                        state  <= ST_LOAD;
                        pc_wr  <= 1'b1;
                        pc_out <= {24'd0, mem_data_in[7:0]};
                        done   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    vec_sel <= SRC_PC;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    vec_sel <= SRC_PC;
                end
            endcase
        end
    end

`ifndef EXC_EPC_EN
    // EPC saving disabled: the port pair is constant and pc_in goes unused.
    logic unused_pc_in;
    assign unused_pc_in = ^pc_in;
    assign epc_wr  = 1'b0;
    assign epc_out = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Address-mux arbitration. Reset forces the PC select immediately,
    // independent of the clock, so memory never sees a stale vector.
    // ------------------------------------------------------------------
    always_comb begin
        src_add_mem = SRC_PC;
        if (!reset) begin
            src_add_mem = SRC_PC;
        end else if (state == ST_IDLE) begin
            src_add_mem = ctrl_src;
        end else begin
            src_add_mem = vec_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exception_sequencer
//  Purpose  : Self-checking bench. Two sequencers (MEM_LAT 1 and 3) share one
//             stimulus stream; a per-instance model tracks the position
//             within an exception sequence and every output is compared on
//             every falling edge, alongside hand-computed spot checks.
//  Config   : EXC_EPC_EN - follows the RTL build option.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exception_sequencer;

`ifdef EXC_EPC_EN
    localparam bit EPC_ON = 1'b1;
`else
    localparam bit EPC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  ctrl_src;
    logic        exc_noop, exc_ovf, exc_div0;
    logic [31:0] pc_in, mem_data_in;

    logic [2:0]  src_o   [2];
    logic        busy_o  [2];
    logic        epcwr_o [2];
    logic [31:0] epc_o   [2];
    logic        pcwr_o  [2];
    logic [31:0] pc_o    [2];
    logic [1:0]  cause_o [2];
    logic        done_o  [2];

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    exception_sequencer #(.MEM_LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset), .ctrl_src(ctrl_src),
        .exc_noop(exc_noop), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data_in(mem_data_in),
        .src_add_mem(src_o[0]), .busy(busy_o[0]), .epc_wr(epcwr_o[0]),
        .epc_out(epc_o[0]), .pc_wr(pcwr_o[0]), .pc_out(pc_o[0]),
        .exc_cause(cause_o[0]), .done(done_o[0]));

    exception_sequencer #(.MEM_LAT(3)) dut_lat3 (
        .clk(clk), .reset(reset), .ctrl_src(ctrl_src),
        .exc_noop(exc_noop), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data_in(mem_data_in),
        .src_add_mem(src_o[1]), .busy(busy_o[1]), .epc_wr(epcwr_o[1]),
        .epc_out(epc_o[1]), .pc_wr(pcwr_o[1]), .pc_out(pc_o[1]),
        .exc_cause(cause_o[1]), .done(done_o[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: pos = 0 when idle, otherwise the 1-based cycle number inside
    // the 2+LAT cycle sequence (1 = save, last = load).
    // ------------------------------------------------------------------
    int         lat  [2] = '{1, 3};
    int         pos  [2] = '{0, 0};
    logic [1:0] mcause [2] = '{2'd0, 2'd0};
    logic [31:0] mepc [2];
    logic [7:0] mmem [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                pos[d]    = 0;
                mcause[d] = 2'd0;
            end else if (pos[d] == 0) begin
                if (exc_div0 || exc_ovf || exc_noop) begin
                    pos[d]    = 1;
                    mcause[d] = exc_div0 ? 2'd3 : (exc_ovf ? 2'd2 : 2'd1);
                    mepc[d]   = pc_in - 32'd4;
                end
            end else if (pos[d] == 2 + lat[d]) begin
                pos[d] = 0;
            end else begin
                pos[d] = pos[d] + 1;
                if (pos[d] == 2 + lat[d]) mmem[d] = mem_data_in[7:0];
            end
        end
    end

    task automatic compare(input int d);
        logic [2:0] e_src;
        logic       e_ewr, e_load;
        e_load = (pos[d] == 2 + lat[d]);
        e_ewr  = EPC_ON && (pos[d] == 1);
        if (!reset)          e_src = 3'd0;
        else if (pos[d] == 0) e_src = ctrl_src;
        else                 e_src = 3'(mcause[d]) + 3'd1;
        chk($sformatf("d%0d_src", d),   32'(src_o[d]),   32'(e_src));
        chk($sformatf("d%0d_busy", d),  32'(busy_o[d]),  32'(pos[d] != 0));
        chk($sformatf("d%0d_epcwr", d), 32'(epcwr_o[d]), 32'(e_ewr));
        chk($sformatf("d%0d_epc", d),   epc_o[d],        e_ewr ? mepc[d] : 32'd0);
        chk($sformatf("d%0d_pcwr", d),  32'(pcwr_o[d]),  32'(e_load));
        chk($sformatf("d%0d_pc", d),    pc_o[d],         e_load ? {24'd0, mmem[d]} : 32'd0);
        chk($sformatf("d%0d_done", d),  32'(done_o[d]),  32'(e_load));
        chk($sformatf("d%0d_cause", d), 32'(cause_o[d]), 32'(mcause[d]));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            compare(0);
            compare(1);
        end
    end

    // Side monitors for busy-run length and PC-write observations
    int          busy_run  [2] = '{0, 0};
    int          last_run  [2] = '{0, 0};
    bit          pcwr_seen [2] = '{1'b0, 1'b0};
    logic [31:0] last_pc   [2] = '{32'd0, 32'd0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (busy_o[d] === 1'b1) begin
                busy_run[d] = busy_run[d] + 1;
            end else if (busy_run[d] > 0) begin
                last_run[d] = busy_run[d];
                busy_run[d] = 0;
            end
            if (pcwr_o[d] === 1'b1) begin
                pcwr_seen[d] = 1'b1;
                last_pc[d]   = pc_o[d];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_exc(input logic div0, input logic ovf, input logic noop);
        exc_div0 = div0; exc_ovf = ovf; exc_noop = noop;
        step(1);
        exc_div0 = 1'b0; exc_ovf = 1'b0; exc_noop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ctrl_src = 3'd5;
        exc_noop = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
        pc_in = 32'h0; mem_data_in = 32'h0;
        step(2);
        armed = 1'b1;
        @(negedge clk);
        // Reset state: select forced to PC even though control asks for 5
        chk("rst_src",   32'(src_o[0]),   32'd0);
        chk("rst_busy",  32'(busy_o[0]),  32'd0);
        chk("rst_cause", 32'(cause_o[1]), 32'd0);
        reset = 1'b1;

        // Idle passthrough
        #1;
        chk("idle_src5", 32'(src_o[0]), 32'd5);
        step(1);
        ctrl_src = 3'd1;
        @(negedge clk);
        chk("idle_src1", 32'(src_o[1]), 32'd1);
        chk("idle_busy", 32'(busy_o[1]), 32'd0);

        // Overflow, pc_in 0x40, handler byte 0x80
        pc_in = 32'h40; mem_data_in = 32'h0000_0080;
        pulse_exc(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovf_save_src",   32'(src_o[0]),   32'd3);
        chk("ovf_save_epcwr", 32'(epcwr_o[0]), 32'(EPC_ON));
        chk("ovf_save_epc",   epc_o[0],        EPC_ON ? 32'h3C : 32'h0);
        chk("ovf_cause",      32'(cause_o[0]), 32'd2);
        step(2);
        @(negedge clk);
        chk("ovf_load_pc",   pc_o[0],        32'h80);
        chk("ovf_load_done", 32'(done_o[0]), 32'd1);
        step(5);
        chk("ovf_busy_len1", 32'(last_run[0]), 32'd3);
        chk("ovf_busy_len3", 32'(last_run[1]), 32'd5);

        // div0 and noop together: div0 wins, noop dropped
        pulse_exc(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("div0_src",   32'(src_o[0]),   32'd4);
        chk("div0_cause", 32'(cause_o[1]), 32'd3);
        step(7);
        chk("div0_idle_after", 32'(busy_o[1]),  32'd0);
        chk("div0_cause_held", 32'(cause_o[0]), 32'd3);

        // noop at pc_in 0; overflow request during WAIT is ignored
        pc_in = 32'h0;
        pulse_exc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("noop_epc_wrap", epc_o[0], EPC_ON ? 32'hFFFF_FFFC : 32'h0);
        step(1);
        pulse_exc(1'b0, 1'b1, 1'b0);
        step(6);
        chk("noop_cause_kept", 32'(cause_o[1]), 32'd1);
        chk("noop_idle",       32'(busy_o[0]),  32'd0);

        // Reset while in WAIT aborts the sequence before any PC write
        pc_in = 32'h100; mem_data_in = 32'hFFFF_FFA5;
        pcwr_seen[0] = 1'b0; pcwr_seen[1] = 1'b0;
        pulse_exc(1'b0, 1'b1, 1'b0);
        step(1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",  32'(busy_o[0]),  32'd0);
        chk("abort_cause", 32'(cause_o[1]), 32'd0);
        step(6);
        chk("abort_no_pcwr1", 32'(pcwr_seen[0]), 32'd0);
        chk("abort_no_pcwr3", 32'(pcwr_seen[1]), 32'd0);

        // High bits of the read data are discarded
        pulse_exc(1'b0, 1'b1, 1'b0);
        step(7);
        chk("a5_pc3",   last_pc[1],  32'h0000_00A5);
        chk("a5_pc1",   last_pc[0],  32'h0000_00A5);
        chk("a5_busy3", 32'(last_run[1]), 32'd5);

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
